// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode/funct encodings, HI/LO register indices
// and the multiply/divide unit state encoding.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [4:0] FUNCT_ADD = 5'b10000;
  localparam logic [4:0] FUNCT_SUB = 5'b10001;
  localparam logic [4:0] FUNCT_AND = 5'b10010;
  localparam logic [4:0] FUNCT_OR  = 5'b10011;
  localparam logic [4:0] FUNCT_MUL = 5'b10100;
  localparam logic [4:0] FUNCT_XOR = 5'b10101;
  localparam logic [4:0] FUNCT_SLT = 5'b11000;
  localparam logic [4:0] FUNCT_DIV = 5'b11100;

  localparam logic [4:0] R_HI = 5'd24;
  localparam logic [4:0] R_LO = 5'd25;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } muldiv_state_t;

  function automatic logic is_muldiv(input logic [4:0] f);
    return (f == FUNCT_MUL) || (f == FUNCT_DIV);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) unit producing
// HI/LO. One shared add/sub serves both ops; results update only on DONE.
module muldiv_unit
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [4:0]        funct,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              div_by_zero,
  output logic [1:0]        dbg_state
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_RUN  = RUN;
  localparam logic [1:0] S_DONE = DONE;

  // Handshake: start is sampled only while busy=0 (IDLE); requests during
  // busy are dropped. done pulses one cycle with hi/lo/div_by_zero valid.
  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] p_hi, p_lo, b_reg;
  logic              is_div, dz_pend;
  logic              accept;

  logic [DATA_W+1:0] add_a, add_b, add_sum;
  logic [DATA_W:0]   mul_pre;
  logic [DATA_W-1:0] nxt_hi, nxt_lo;
  logic              no_borrow;

  assign accept    = (state == S_IDLE) && start && !flush && is_muldiv(funct);
  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

  // Divide trials subtract from the shifted remainder, which needs DATA_W+1
  // bits; the extra top bit of the sum is the borrow.
  always_comb begin
    add_a     = is_div ? {1'b0, p_hi, p_lo[DATA_W-1]} : {2'b00, p_hi};
    add_b     = is_div ? ~{2'b00, b_reg} : {2'b00, b_reg};
    add_sum   = add_a + add_b + {{(DATA_W+1){1'b0}}, is_div};
    no_borrow = ~add_sum[DATA_W+1];
    mul_pre   = p_lo[0] ? add_sum[DATA_W:0] : {1'b0, p_hi};
    if (is_div) begin
      nxt_hi = no_borrow ? add_sum[DATA_W-1:0] : {p_hi[DATA_W-2:0], p_lo[DATA_W-1]};
      nxt_lo = {p_lo[DATA_W-2:0], no_borrow};
    end else begin
      nxt_hi = mul_pre[DATA_W:1];
      nxt_lo = {mul_pre[0], p_lo[DATA_W-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      p_hi        <= '0;
      p_lo        <= '0;
      b_reg       <= '0;
      is_div      <= 1'b0;
      dz_pend     <= 1'b0;
      done        <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            b_reg   <= op_b;
            is_div  <= (funct == FUNCT_DIV);
            cnt     <= CNT_W'(DATA_W - 1);
            if ((funct == FUNCT_DIV) && (op_b == '0)) begin
              // Preload the divide-by-zero result so DONE commits it uniformly.
              p_hi    <= op_a;
              p_lo    <= '1;
              dz_pend <= 1'b1;
              state   <= S_DONE;
            end else begin
              p_hi    <= '0;
              p_lo    <= op_a;
              dz_pend <= 1'b0;
              state   <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (flush) begin
            state <= S_IDLE;
          end else begin
            p_hi <= nxt_hi;
            p_lo <= nxt_lo;
            if (cnt == '0) state <= S_DONE;
            else           cnt   <= cnt - 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          if (!flush) begin
            done        <= 1'b1;
            hi          <= p_hi;
            lo          <= p_lo;
            div_by_zero <= dz_pend;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random
// mul/div traffic compared against an arithmetic reference model.
module tb_muldiv_unit;
  import cpu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [4:0]   funct = 5'd0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         flush = 1'b0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;
  logic [1:0]   dbg_state;

  muldiv_unit #(.DATA_W(W), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct(funct),
    .op_a(op_a), .op_b(op_b), .flush(flush), .busy(busy), .done(done),
    .hi(hi), .lo(lo), .div_by_zero(div_by_zero), .dbg_state(dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard: {div_by_zero, hi, lo}
  logic [2*W:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int t0       = 0;
  logic [W-1:0] last_hi = '0, last_lo = '0;
  logic         last_dz = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [2*W:0] ref_op(input logic [4:0] f, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    logic [63:0] prod;
    if (f == FUNCT_MUL) begin
      prod = 64'(a) * 64'(b);
      return {1'b0, prod};
    end
    if (b == 0) return {1'b1, a, {W{1'b1}}};
    return {1'b0, a % b, a / b};
  endfunction

  // driver tasks
  task automatic launch(input logic [4:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start = 1'b1; funct = f; op_a = a; op_b = b;
    @(posedge clk);
    #1;
    t0 = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_lat);
    int lat;
    logic [2*W:0] e;
    lat = -1;
    for (int i = 0; i < 80; i++) begin
      if (done) begin
        lat = cyc - t0;
        break;
      end
      @(posedge clk);
      #1;
    end
    check({tag, ".lat"}, 64'(lat), 64'(exp_lat));
    e = exp_q.pop_front();
    check({tag, ".hi"}, 64'(hi), 64'(e[2*W-1:W]));
    check({tag, ".lo"}, 64'(lo), 64'(e[W-1:0]));
    check({tag, ".dz"}, 64'(div_by_zero), 64'(e[2*W]));
    last_hi = e[2*W-1:W];
    last_lo = e[W-1:0];
    last_dz = e[2*W];
  endtask

  task automatic do_op(input string tag, input logic [4:0] f, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    exp_q.push_back(ref_op(f, a, b));
    launch(f, a, b);
    check({tag, ".busy"}, 64'(busy), 64'd1);
    wait_done(tag, (f == FUNCT_DIV && b == 0) ? 1 : W + 1);
  endtask

  task automatic count_done(input string tag, input int ncyc);
    int n;
    n = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk);
      #1;
      if (done) n++;
    end
    check({tag, ".no_done"}, 64'(n), 64'd0);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.done", 64'(done), 64'd0);
    check("rst.hi", 64'(hi), 64'd0);
    check("rst.lo", 64'(lo), 64'd0);
    check("rst.dz", 64'(div_by_zero), 64'd0);
    check("rst.state", 64'(dbg_state), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op("mul7x6", FUNCT_MUL, 32'd7, 32'd6);
    do_op("mul_max", FUNCT_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op("div100_7", FUNCT_DIV, 32'd100, 32'd7);
    do_op("div_msb_1", FUNCT_DIV, 32'h8000_0000, 32'd1);
    do_op("div5_0", FUNCT_DIV, 32'd5, 32'd0);
    do_op("mul3x3", FUNCT_MUL, 32'd3, 32'd3);

    // start while busy must be ignored
    exp_q.push_back(ref_op(FUNCT_MUL, 32'd1234, 32'd5678));
    launch(FUNCT_MUL, 32'd1234, 32'd5678);
    repeat (9) @(posedge clk);
    @(negedge clk);
    start = 1'b1; funct = FUNCT_DIV; op_a = 32'd999; op_b = 32'd0;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("busy_start", W + 1);

    // flush mid-run: no done, outputs retained
    launch(FUNCT_MUL, 32'hDEAD, 32'hBEEF);
    repeat (18) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush.busy", 64'(busy), 64'd0);
    count_done("flush", 45);
    check("flush.hi", 64'(hi), 64'(last_hi));
    check("flush.lo", 64'(lo), 64'(last_lo));

    // unsupported funct
    launch(FUNCT_ADD, 32'd11, 32'd22);
    check("add.busy", 64'(busy), 64'd0);
    count_done("add", 40);
    check("add.lo", 64'(lo), 64'(last_lo));

    // async reset mid-divide
    launch(FUNCT_DIV, 32'd1000, 32'd3);
    repeat (13) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst.busy", 64'(busy), 64'd0);
    check("arst.hi", 64'(hi), 64'd0);
    check("arst.lo", 64'(lo), 64'd0);
    check("arst.dz", 64'(div_by_zero), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    count_done("arst", 45);
    do_op("div9_3", FUNCT_DIV, 32'd9, 32'd3);

    // random traffic, back-to-back
    for (int i = 0; i < 24; i++) begin
      logic [4:0]   f;
      logic [W-1:0] a, b;
      int sel;
      f   = ($urandom_range(0, 1) == 1) ? FUNCT_DIV : FUNCT_MUL;
      a   = $urandom;
      sel = $urandom_range(0, 3);
      b   = (sel == 0) ? '0 : (sel == 1) ? W'($urandom_range(1, 15)) : W'($urandom);
      do_op($sformatf("rnd%0d", i), f, a, b);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
